alu_decode_stage: RTL and testbench
===================================

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 SHALL have parameter ILL_CNT_W, default 8, width of the saturating illegal-instruction counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports in_valid input 1, in_ready output 1, in_instr input 32, in_pc input 32: upstream (fetch) handshake and payload.
REQ-005 SHALL have port flush  input  1  discard the held entry and leave TRAP.
REQ-006 SHALL have ports out_valid output 1, out_ready input 1: downstream (execute) handshake.
REQ-007 SHALL have payload outputs aluSelect 6, rs1 5, rs2 5, rd 5, imm 32, use_imm 1, reg_write 1, illegal 1, out_pc 32.
REQ-008 SHALL have output trap 1 (high in TRAP state) and output ill_count ILL_CNT_W.

Function
REQ-009 SHALL decode opcode 0010011 by funct3: 000 ADDI 010011, 010 SLTI 010100, 011 SLTIU 010101, 100 XORI 010110, 110 ORI 010111, 111 ANDI 011000.
REQ-010 SHALL decode I-shifts: funct3 001 with funct7 0000000 SLLI 011001; funct3 101 with funct7 0000000 SRLI 011010, with 0100000 SRAI 011011; any other funct7 illegal.
REQ-011 SHALL decode opcode 0110011, funct7 0000000: 000 ADD 011100, 001 SLL 011101, 010 SLT 011110, 011 SLTU 011111, 100 XOR 100000, 101 SRL 100001, 110 OR 100010, 111 AND 100011.
REQ-012 SHALL decode opcode 0110011, funct7 0100000: 000 SUB 100100, 101 SRA 100101; other funct3 illegal.
REQ-013 SHALL treat every other opcode/funct combination as illegal: aluSelect 111111, illegal=1, reg_write=0, use_imm=0, imm=0.
REQ-014 imm SHALL be sign-extended instr[31:20] for non-shift I-type, zero-extended instr[24:20] for I-shifts, 0 for R-type.
REQ-015 use_imm SHALL be 1 for legal I-type, 0 otherwise; reg_write SHALL be 1 for legal instructions with rd!=0, else 0.
REQ-016 Payload SHALL be registered: one cycle latency from accepted input (in_valid&&in_ready) to out_valid.
REQ-017 in_ready SHALL equal (state==RUN) && (!out_valid || out_ready); payload and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-018 out_valid SHALL clear on a cycle where out_ready=1 and no new input is accepted.
REQ-019 States RUN, TRAP: RUN->TRAP when an illegal instruction is accepted; TRAP->RUN only on flush.
REQ-020 In TRAP in_ready SHALL be 0; the illegal entry SHALL still be presented downstream until consumed.
REQ-021 ill_count SHALL increment on each accepted illegal instruction and saturate at all-ones.
REQ-022 flush SHALL clear out_valid next cycle and force RUN; flush with simultaneous in_valid SHALL drop the input (in_ready=0 during flush).
REQ-023 flush SHALL NOT alter ill_count.

Reset
REQ-024 On reset SHALL set state RUN, out_valid 0, aluSelect 111111, all other payload outputs 0, ill_count 0, trap 0; reset overrides flush and in_valid.
REQ-025 Reset asserted mid-transfer SHALL discard the held entry with no out_valid pulse.

Structure
REQ-026 The 6-bit aluSelect codes, opcode/funct3/funct7 constants and the state encoding SHALL live in a shared package used also by the execute-stage ALU.
REQ-027 Combinational decode SHALL be a sub-module alu_select_decoder (instr in, aluSelect/imm/use_imm/reg_write/illegal out); the stage adds handshake, FSM and counter.

Verification
REQ-028 0x00500093 (ADDI x1,x0,5), out_ready=1 -> next cycle out_valid=1, aluSelect 010011, rd=1, rs1=0, imm=5, use_imm=1, reg_write=1.
REQ-029 0x402081B3 (SUB x3,x1,x2) -> aluSelect 100100, rs1=1, rs2=2, rd=3, imm=0, use_imm=0.
REQ-030 0x40335293 (SRAI x5,x6,3) -> aluSelect 011011, rs1=6, rd=5, imm=3; same with funct7 0000001 (0x02335293) -> illegal=1, aluSelect 111111.
REQ-031 out_ready=0 for 3 cycles after ADD accepted -> in_ready=0, payload unchanged all 3 cycles; out_ready=1 -> in_ready=1 same cycle, next instruction accepted.
REQ-032 0x00000000 accepted -> illegal=1, trap=1, ill_count=1, in_ready=0 with in_valid held; flush -> out_valid=0, trap=0 next cycle, ill_count stays 1.
REQ-033 256 illegal instructions with flush between -> ill_count saturates at 255.

Source files
------------

// File: rtl/alu_decode_stage_pkg.sv
// Shared decode constants: ALU select codes, RV32I opcode/funct fields and
// the decode-stage state encoding. Also imported by the execute-stage ALU.
package alu_decode_stage_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [5:0] ALU_ADDI    = 6'b010011;
    localparam logic [5:0] ALU_SLTI    = 6'b010100;
    localparam logic [5:0] ALU_SLTIU   = 6'b010101;
    localparam logic [5:0] ALU_XORI    = 6'b010110;
    localparam logic [5:0] ALU_ORI     = 6'b010111;
    localparam logic [5:0] ALU_ANDI    = 6'b011000;
    localparam logic [5:0] ALU_SLLI    = 6'b011001;
    localparam logic [5:0] ALU_SRLI    = 6'b011010;
    localparam logic [5:0] ALU_SRAI    = 6'b011011;
    localparam logic [5:0] ALU_ADD     = 6'b011100;
    localparam logic [5:0] ALU_SLL     = 6'b011101;
    localparam logic [5:0] ALU_SLT     = 6'b011110;
    localparam logic [5:0] ALU_SLTU    = 6'b011111;
    localparam logic [5:0] ALU_XOR     = 6'b100000;
    localparam logic [5:0] ALU_SRL     = 6'b100001;
    localparam logic [5:0] ALU_OR      = 6'b100010;
    localparam logic [5:0] ALU_AND     = 6'b100011;
    localparam logic [5:0] ALU_SUB     = 6'b100100;
    localparam logic [5:0] ALU_SRA     = 6'b100101;
    localparam logic [5:0] ALU_ILLEGAL = 6'b111111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } stage_state_e;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/alu_select_decoder.sv
// Purely combinational RV32I ALU-instruction decoder: maps an instruction word
// to an ALU select code, immediate, operand fields and write-enable.
module alu_select_decoder
    import alu_decode_stage_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  aluSelect,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic        use_imm,
    output logic        reg_write,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];

    always_comb begin
        aluSelect = ALU_ILLEGAL;
        imm       = 32'h0;
        use_imm   = 1'b0;
        legal     = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                case (funct3)
                    F3_ADD_SUB: begin aluSelect = ALU_ADDI;  legal = 1'b1; end
                    F3_SLT:     begin aluSelect = ALU_SLTI;  legal = 1'b1; end
                    F3_SLTU:    begin aluSelect = ALU_SLTIU; legal = 1'b1; end
                    F3_XOR:     begin aluSelect = ALU_XORI;  legal = 1'b1; end
                    F3_OR:      begin aluSelect = ALU_ORI;   legal = 1'b1; end
                    F3_AND:     begin aluSelect = ALU_ANDI;  legal = 1'b1; end
                    F3_SLL: begin
                        if (funct7 == F7_BASE) begin
                            aluSelect = ALU_SLLI;
                            legal     = 1'b1;
                        end
                    end
                    F3_SRL_SRA: begin
                        if (funct7 == F7_BASE) begin
                            aluSelect = ALU_SRLI;
                            legal     = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            aluSelect = ALU_SRAI;
                            legal     = 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (legal) begin
                    use_imm = 1'b1;
                    // Shifts carry only a 5-bit shamt; funct7 is not part of the operand.
                    if (funct3 == F3_SLL || funct3 == F3_SRL_SRA)
                        imm = {27'h0, instr[24:20]};
                    else
                        imm = sext12(instr[31:20]);
                end
            end
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    legal = 1'b1;
                    case (funct3)
                        F3_ADD_SUB: aluSelect = ALU_ADD;
                        F3_SLL:     aluSelect = ALU_SLL;
                        F3_SLT:     aluSelect = ALU_SLT;
                        F3_SLTU:    aluSelect = ALU_SLTU;
                        F3_XOR:     aluSelect = ALU_XOR;
                        F3_SRL_SRA: aluSelect = ALU_SRL;
                        F3_OR:      aluSelect = ALU_OR;
                        default:    aluSelect = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == F3_ADD_SUB) begin
                        aluSelect = ALU_SUB;
                        legal     = 1'b1;
                    end else if (funct3 == F3_SRL_SRA) begin
                        aluSelect = ALU_SRA;
                        legal     = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign illegal   = !legal;
    assign reg_write = legal && (rd != 5'd0);

endmodule

// File: rtl/alu_decode_stage.sv
// Registered decode stage: valid/ready handshake around alu_select_decoder,
// RUN/TRAP control on illegal instructions and a saturating illegal counter.
module alu_decode_stage
    import alu_decode_stage_pkg::*;
#(
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [31:0]          in_pc,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [5:0]           aluSelect,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [4:0]           rd,
    output logic [31:0]          imm,
    output logic                 use_imm,
    output logic                 reg_write,
    output logic                 illegal,
    output logic [31:0]          out_pc,
    output logic                 trap,
    output logic [ILL_CNT_W-1:0] ill_count
);

    logic [5:0]  dec_sel;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [31:0] dec_imm;
    logic        dec_use_imm, dec_reg_write, dec_illegal;

    alu_select_decoder u_dec (
        .instr     (in_instr),
        .aluSelect (dec_sel),
        .rs1       (dec_rs1),
        .rs2       (dec_rs2),
        .rd        (dec_rd),
        .imm       (dec_imm),
        .use_imm   (dec_use_imm),
        .reg_write (dec_reg_write),
        .illegal   (dec_illegal)
    );

    stage_state_e        state_q, state_d;
    logic                valid_q, valid_d;
    logic [5:0]          sel_q, sel_d;
    logic [4:0]          rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [31:0]         imm_q, imm_d, pc_q, pc_d;
    logic                use_imm_q, use_imm_d;
    logic                reg_write_q, reg_write_d;
    logic                illegal_q, illegal_d;
    logic [ILL_CNT_W-1:0] cnt_q, cnt_d;
    logic                accept;

    // Flush blocks acceptance so a concurrent input is dropped, not latched.
    assign in_ready = (state_q == ST_RUN) && (!valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        sel_d       = sel_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
        use_imm_d   = use_imm_q;
        reg_write_d = reg_write_q;
        illegal_d   = illegal_q;
        cnt_d       = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            state_d = ST_RUN;
        end else if (accept) begin
            valid_d     = 1'b1;
            sel_d       = dec_sel;
            rs1_d       = dec_rs1;
            rs2_d       = dec_rs2;
            rd_d        = dec_rd;
            imm_d       = dec_imm;
            pc_d        = in_pc;
            use_imm_d   = dec_use_imm;
            reg_write_d = dec_reg_write;
            illegal_d   = dec_illegal;
            if (dec_illegal) begin
                state_d = ST_TRAP;
                if (cnt_q != {ILL_CNT_W{1'b1}})
                    cnt_d = cnt_q + ILL_CNT_W'(1);
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            valid_q     <= 1'b0;
            sel_q       <= ALU_ILLEGAL;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            rd_q        <= 5'd0;
            imm_q       <= 32'h0;
            pc_q        <= 32'h0;
            use_imm_q   <= 1'b0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            sel_q       <= sel_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            use_imm_q   <= use_imm_d;
            reg_write_q <= reg_write_d;
            illegal_q   <= illegal_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign aluSelect = sel_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign rd        = rd_q;
    assign imm       = imm_q;
    assign use_imm   = use_imm_q;
    assign reg_write = reg_write_q;
    assign illegal   = illegal_q;
    assign out_pc    = pc_q;
    assign trap      = (state_q == ST_TRAP);
    assign ill_count = cnt_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed testbench for alu_decode_stage: decode vectors, backpressure,
// trap/flush behaviour, counter saturation and reset mid-transfer.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, out_ready;
    logic        in_ready, out_valid, use_imm, reg_write, illegal, trap;
    logic [31:0] in_instr, in_pc, imm, out_pc;
    logic [5:0]  aluSelect;
    logic [4:0]  rs1, rs2, rd;
    logic [7:0]  ill_count;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    alu_decode_stage #(.ILL_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .aluSelect(aluSelect),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .use_imm(use_imm),
        .reg_write(reg_write), .illegal(illegal), .out_pc(out_pc),
        .trap(trap), .ill_count(ill_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_instr = 32'h0; in_pc = 32'h0;
        tick(); tick();
        reset = 1'b0;
        exp_cnt = 0;
    endtask

    // Accepts one instruction with out_ready=1 and leaves in_valid low after.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1; in_instr = instr; in_pc = pc; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        $display("txn instr=0x%08h pc=0x%08h sel=%06b rd=%0d", instr, pc, aluSelect, rd);
    endtask

    task automatic test_reset();
        do_reset();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_sel", {26'b0, aluSelect}, 32'h3F);
        chk("rst_imm", imm, 32'd0);
        chk("rst_rd", {27'b0, rd}, 32'd0);
        chk("rst_trap", {31'b0, trap}, 32'd0);
        chk("rst_cnt", {24'b0, ill_count}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic test_addi();
        send(32'h00500093, 32'h100);
        chk("addi_valid", {31'b0, out_valid}, 32'd1);
        chk("addi_sel", {26'b0, aluSelect}, 32'b010011);
        chk("addi_rd", {27'b0, rd}, 32'd1);
        chk("addi_rs1", {27'b0, rs1}, 32'd0);
        chk("addi_imm", imm, 32'd5);
        chk("addi_use_imm", {31'b0, use_imm}, 32'd1);
        chk("addi_wr", {31'b0, reg_write}, 32'd1);
        chk("addi_pc", out_pc, 32'h100);
        tick();
        chk("addi_drain", {31'b0, out_valid}, 32'd0);
        send(32'h00100013, 32'h104); // ADDI x0,x0,1
        chk("addi_x0_wr", {31'b0, reg_write}, 32'd0);
        chk("addi_x0_ill", {31'b0, illegal}, 32'd0);
        tick();
    endtask

    task automatic test_sub();
        send(32'h402081B3, 32'h108);
        chk("sub_sel", {26'b0, aluSelect}, 32'b100100);
        chk("sub_fields", {17'b0, rs1, rs2, rd}, {17'b0, 5'd1, 5'd2, 5'd3});
        chk("sub_imm", imm, 32'd0);
        chk("sub_use_imm", {31'b0, use_imm}, 32'd0);
        tick();
    endtask

    task automatic test_srai();
        send(32'h40335293, 32'h10C);
        chk("srai_sel", {26'b0, aluSelect}, 32'b011011);
        chk("srai_fields", {22'b0, rs1, rd}, {22'b0, 5'd6, 5'd5});
        chk("srai_imm", imm, 32'd3);
        tick();
        send(32'h02335293, 32'h110);
        exp_cnt++;
        chk("srai_bad_ill", {31'b0, illegal}, 32'd1);
        chk("srai_bad_sel", {26'b0, aluSelect}, 32'h3F);
        chk("srai_bad_imm", imm, 32'd0);
        chk("srai_bad_wr", {31'b0, reg_write}, 32'd0);
        flush = 1'b1; tick(); flush = 1'b0;
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_instr = 32'h003100B3; in_pc = 32'h200; out_ready = 1'b0;
        tick();
        in_instr = 32'hFFF44393; in_pc = 32'h204;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_hold", {6'b0, out_valid, aluSelect, rd, rs1, rs2, 4'b0},
                {6'b0, 1'b1, 6'b011100, 5'd1, 5'd2, 5'd3, 4'b0});
            chk("bp_pc", out_pc, 32'h200);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        $display("txn instr=0xfff44393 pc=0x00000204 sel=%06b rd=%0d", aluSelect, rd);
        chk("bp_xori_sel", {26'b0, aluSelect}, 32'b010110);
        chk("bp_xori_imm", imm, 32'hFFFFFFFF);
        chk("bp_xori_fields", {22'b0, rs1, rd}, {22'b0, 5'd8, 5'd7});
        tick();
    endtask

    task automatic test_trap_flush();
        do_reset();
        send(32'h00000000, 32'h300);
        exp_cnt++;
        in_valid = 1'b1; in_instr = 32'h00500093;
        #1;
        chk("trap_ill", {31'b0, illegal}, 32'd1);
        chk("trap_trap", {31'b0, trap}, 32'd1);
        chk("trap_cnt", {24'b0, ill_count}, 32'd1);
        chk("trap_in_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b0;
        tick();
        chk("trap_still_valid", {31'b0, out_valid}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_trap", {31'b0, trap}, 32'd0);
        chk("flush_cnt", {24'b0, ill_count}, 32'd1);
        out_ready = 1'b1;
    endtask

    task automatic test_flush_drop();
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h400; out_ready = 1'b0;
        tick();
        in_instr = 32'h402081B3; out_ready = 1'b1; flush = 1'b1;
        #1;
        chk("fd_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fd_valid0", {31'b0, out_valid}, 32'd0);
        tick();
        chk("fd_dropped", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 256; i++) begin
            send(32'h00000000, i);
            if (exp_cnt < 255) exp_cnt++;
            flush = 1'b1; tick(); flush = 1'b0;
        end
        chk("sat_cnt", {24'b0, ill_count}, exp_cnt);
        chk("sat_cnt_255", {24'b0, ill_count}, 32'd255);
        send(32'h00000000, 32'h500);
        chk("sat_hold", {24'b0, ill_count}, 32'd255);
        chk("sat_trap", {31'b0, trap}, 32'd1);
        flush = 1'b1; tick(); flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_instr = 32'h003100B3; in_pc = 32'h600; out_ready = 1'b0;
        tick();
        chk("rm_pre_valid", {31'b0, out_valid}, 32'd1);
        reset = 1'b1; flush = 1'b1; out_ready = 1'b1;
        tick();
        chk("rm_valid", {31'b0, out_valid}, 32'd0);
        chk("rm_sel", {26'b0, aluSelect}, 32'h3F);
        chk("rm_pc", out_pc, 32'd0);
        chk("rm_cnt", {24'b0, ill_count}, 32'd0);
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("rm_no_pulse", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sub();
        test_srai();
        test_backpressure();
        test_trap_flush();
        test_flush_drop();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
